fpmac_dot_sequencer: RTL and testbench

//  Sequences dot-product jobs on the FP16 multiply-accumulate datapath (MAC_LAT-stage pipeline, 1-cycle acc loop).

---
 rtl/fpmac_pkg.sv | 18 +
 rtl/fpmac_dot_sequencer.sv | 167 ++++++++++++++++
 tb/tb_fpmac_dot_sequencer.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpmac_pkg.sv
// rtl/fpmac_pkg.sv - shared types and constants for the FP16 MAC dot-product sequencer
// Purpose: sequencer state encoding, FP16 width/zero constants and default MAC latency.
// Ports: none (package).
package fpmac_pkg;

  localparam int          FP16_W      = 16;
  localparam logic [15:0] FP16_ZERO   = 16'h0000;
  localparam int          DEF_MAC_LAT = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/fpmac_dot_sequencer.sv
// rtl/fpmac_dot_sequencer.sv - job sequencer driving the FP16 multiply-accumulate datapath
// Purpose: accepts a dot-product job (start + len), clears the MAC, streams operand
//   pairs into it, flushes the MAC pipeline with +0 products and captures the sum.
// Ports:
//   clk, Asynch_Reset          clock, async active-low reset
//   start, len, abort, busy    job control / status
//   in_valid, in_ready,        operand stream from source
//   in_a, in_b
//   mac_en, mac_clr,           MAC control and operands (registered)
//   mac_a, mac_b, mac_acc      plus accumulator feedback
//   done, result, err_len      completion pulse, held sum, zero-length error pulse
module fpmac_dot_sequencer
  import fpmac_pkg::*;
#(
  parameter int LEN_W   = 8,
  parameter int MAC_LAT = DEF_MAC_LAT
) (
  input  logic              clk,
  input  logic              Asynch_Reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              abort,
  output logic              busy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FP16_W-1:0] in_a,
  input  logic [FP16_W-1:0] in_b,
  output logic              mac_en,
  output logic              mac_clr,
  output logic [FP16_W-1:0] mac_a,
  output logic [FP16_W-1:0] mac_b,
  input  logic [FP16_W-1:0] mac_acc,
  output logic              done,
  output logic [FP16_W-1:0] result,
  output logic              err_len
);

  localparam int DRN_W = $clog2(MAC_LAT + 1);

  state_t            r_state, w_next;
  logic [LEN_W-1:0]  r_rem, w_rem;
  logic [DRN_W-1:0]  r_drn, w_drn;
  logic              r_mac_en, w_mac_en;
  logic              r_mac_clr, w_mac_clr;
  logic [FP16_W-1:0] r_mac_a, w_mac_a;
  logic [FP16_W-1:0] r_mac_b, w_mac_b;
  logic              r_done, w_done;
  logic [FP16_W-1:0] r_result, w_result;
  logic              r_err_len, w_err_len;
  logic              w_beat;

  assign w_beat = in_valid && (r_state == ST_FEED);

  always_comb begin
    w_next    = r_state;
    w_rem     = r_rem;
    w_drn     = r_drn;
    w_mac_en  = 1'b0;
    w_mac_clr = 1'b0;
    w_mac_a   = FP16_ZERO;
    w_mac_b   = FP16_ZERO;
    w_done    = 1'b0;
    w_result  = r_result;
    w_err_len = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (len != '0) begin
            w_next    = ST_CLEAR;
            w_rem     = len;
            // Registered, so the clear pulse lands in the CLEAR cycle.
            w_mac_clr = 1'b1;
          end else begin
            w_err_len = 1'b1;
          end
        end
      end
      ST_CLEAR: begin
        w_next = ST_FEED;
      end
      ST_FEED: begin
        if (w_beat) begin
          w_mac_en = 1'b1;
          w_mac_a  = in_a;
          w_mac_b  = in_b;
          if (r_rem != '0) begin
            w_rem = r_rem - LEN_W'(1);
          end
          if (r_rem == LEN_W'(1)) begin
            w_next = ST_DRAIN;
            w_drn  = DRN_W'(MAC_LAT);
          end
        end
      end
      ST_DRAIN: begin
        // Zero operands push the last real product through; the sum is unchanged.
        w_mac_en = 1'b1;
        if (r_drn != '0) begin
          w_drn = r_drn - DRN_W'(1);
        end
        if (r_drn == DRN_W'(1)) begin
          // Accumulator is final by now; capture it so result and done align.
          w_next   = ST_DONE;
          w_done   = 1'b1;
          w_result = mac_acc;
        end
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase

    // Abort overrides everything, including a final beat or the DONE transition.
    if (abort && (r_state != ST_IDLE)) begin
      w_next    = ST_IDLE;
      w_rem     = '0;
      w_drn     = '0;
      w_mac_en  = 1'b0;
      w_mac_clr = 1'b1;
      w_mac_a   = FP16_ZERO;
      w_mac_b   = FP16_ZERO;
      w_done    = 1'b0;
      w_result  = r_result;
    end
  end

  always_ff @(posedge clk or negedge Asynch_Reset) begin
    if (!Asynch_Reset) begin
      r_state   <= ST_IDLE;
      r_rem     <= '0;
      r_drn     <= '0;
      r_mac_en  <= 1'b0;
      r_mac_clr <= 1'b0;
      r_mac_a   <= FP16_ZERO;
      r_mac_b   <= FP16_ZERO;
      r_done    <= 1'b0;
      r_result  <= FP16_ZERO;
      r_err_len <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_rem     <= w_rem;
      r_drn     <= w_drn;
      r_mac_en  <= w_mac_en;
      r_mac_clr <= w_mac_clr;
      r_mac_a   <= w_mac_a;
      r_mac_b   <= w_mac_b;
      r_done    <= w_done;
      r_result  <= w_result;
      r_err_len <= w_err_len;
    end
  end

  assign busy     = (r_state != ST_IDLE);
  assign in_ready = (r_state == ST_FEED);
  assign mac_en   = r_mac_en;
  assign mac_clr  = r_mac_clr;
  assign mac_a    = r_mac_a;
  assign mac_b    = r_mac_b;
  assign done     = r_done;
  assign result   = r_result;
  assign err_len  = r_err_len;

endmodule

// File: tb/tb_fpmac_dot_sequencer.sv
// tb/tb_fpmac_dot_sequencer.sv - directed self-checking bench for fpmac_dot_sequencer
module tb_fpmac_dot_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  len = 8'd0;
  logic        abort = 1'b0;
  logic        busy;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = 16'h0;
  logic [15:0] in_b = 16'h0;
  logic        mac_en;
  logic        mac_clr;
  logic [15:0] mac_a;
  logic [15:0] mac_b;
  logic [15:0] mac_acc;
  logic        done;
  logic [15:0] result;
  logic        err_len;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_en     = 0;
  int n_clr    = 0;
  int n_done   = 0;
  int n_err    = 0;
  int beat_cyc = 0;
  int done_cyc = 0;

  fpmac_dot_sequencer #(.LEN_W(8), .MAC_LAT(3)) u_dut (
    .clk          (clk),
    .Asynch_Reset (rst_n),
    .start        (start),
    .len          (len),
    .abort        (abort),
    .busy         (busy),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .mac_en       (mac_en),
    .mac_clr      (mac_clr),
    .mac_a        (mac_a),
    .mac_b        (mac_b),
    .mac_acc      (mac_acc),
    .done         (done),
    .result       (result),
    .err_len      (err_len)
  );

  always #5 clk = ~clk;

  function automatic real h2r(input logic [15:0] h);
    real m;
    int  e;
    if (h[14:10] == 5'd0) return 0.0;
    m = 1.0 + real'(h[9:0]) / 1024.0;
    e = int'(h[14:10]) - 15;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return h[15] ? -m : m;
  endfunction

  function automatic logic [15:0] r2h(input real r);
    real  m;
    int   e;
    logic s;
    if (r == 0.0) return 16'h0000;
    s = (r < 0.0);
    m = s ? -r : r;
    e = 15;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0)  begin m = m * 2.0; e--; end
    return {s, 5'(e), 10'($rtoi((m - 1.0) * 1024.0 + 0.5))};
  endfunction

  // Behavioural MAC: product stage then accumulate, both advancing on mac_en.
  real m_p1 = 0.0;
  real m_acc = 0.0;
  always @(posedge clk) begin
    if (mac_clr) begin
      m_p1  <= 0.0;
      m_acc <= 0.0;
    end else if (mac_en) begin
      m_acc <= m_acc + m_p1;
      m_p1  <= h2r(mac_a) * h2r(mac_b);
    end
  end
  always_comb mac_acc = r2h(m_acc);

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (mac_en)  n_en++;
    if (mac_clr) n_clr++;
    if (done)    n_done++;
    if (err_len) n_err++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    n_en = 0; n_clr = 0; n_done = 0; n_err = 0;
  endtask

  task automatic start_job(input logic [7:0] l);
    len = l;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send_pair(input logic [15:0] a, input logic [15:0] b, input int gap);
    bit ok;
    in_valid = 1'b0;
    for (int g = 0; g < gap; g++) step();
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (in_ready) begin ok = 1'b1; break; end
      step();
    end
    if (!ok) check("in_ready_timeout", 32'd0, 32'd1);
    beat_cyc = cyc;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (done) begin ok = 1'b1; break; end
      step();
    end
    check("done_seen", 32'(ok), 32'd1);
    done_cyc = cyc;
  endtask

  initial begin
    // Reset state
    step();
    step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_mac_en", 32'(mac_en), 32'd0);
    check("rst_mac_clr", 32'(mac_clr), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err_len", 32'(err_len), 32'd0);
    check("rst_result", 32'(result), 32'h0000);
    check("rst_mac_ab", {mac_a, mac_b}, 32'h0);
    rst_n = 1'b1;
    step();

    // 1: len=2 back-to-back, 1*2+2*3 = 8
    clear_counts();
    start_job(8'd2);
    check("t1_clear", 32'(mac_clr), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_ready_in_clear", 32'(in_ready), 32'd0);
    send_pair(16'h3C00, 16'h4000, 0);
    send_pair(16'h4000, 16'h4200, 0);
    check("t1_drain_ready", 32'(in_ready), 32'd0);
    wait_done();
    check("t1_result", 32'(result), 32'h4800);
    check("t1_latency", 32'(done_cyc - beat_cyc), 32'd4);
    step();
    check("t1_done_pulse", 32'(done), 32'd0);
    check("t1_idle", 32'(busy), 32'd0);
    check("t1_mac_en_count", 32'(n_en), 32'd5);

    // 3: zero length
    clear_counts();
    start_job(8'd0);
    check("t3_err", 32'(err_len), 32'd1);
    check("t3_busy", 32'(busy), 32'd0);
    step();
    check("t3_err_pulse", 32'(err_len), 32'd0);
    step();
    check("t3_err_count", 32'(n_err), 32'd1);
    check("t3_no_mac", 32'(n_en + n_clr), 32'd0);

    // 4: abort after 1 of 4 beats, then len=1 2*2 = 4
    clear_counts();
    start_job(8'd4);
    send_pair(16'h3C00, 16'h3C00, 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_clr", 32'(mac_clr), 32'd1);
    for (int i = 0; i < 6; i++) step();
    check("t4_no_done", 32'(n_done), 32'd0);
    check("t4_result_kept", 32'(result), 32'h4800);
    start_job(8'd1);
    send_pair(16'h4000, 16'h4000, 0);
    wait_done();
    check("t4_result", 32'(result), 32'h4400);
    step();

    // 2: len=3 with 2-cycle gaps, 1*1*3 = 3
    clear_counts();
    start_job(8'd3);
    send_pair(16'h3C00, 16'h3C00, 0);
    send_pair(16'h3C00, 16'h3C00, 2);
    send_pair(16'h3C00, 16'h3C00, 2);
    wait_done();
    check("t2_result", 32'(result), 32'h4200);
    check("t2_latency", 32'(done_cyc - beat_cyc), 32'd4);
    step();
    check("t2_mac_en_count", 32'(n_en), 32'd6);

    // 5: start held through the job and the DONE cycle
    clear_counts();
    len = 8'd1;
    start = 1'b1;
    step();
    send_pair(16'h3C00, 16'h4000, 0);
    wait_done();
    check("t5_result1", 32'(result), 32'h4000);
    check("t5_one_clear", 32'(n_clr), 32'd1);
    step();
    check("t5_idle_after_done", 32'(busy), 32'd0);
    step();
    start = 1'b0;
    check("t5_second_start", 32'(mac_clr), 32'd1);
    send_pair(16'h4000, 16'h4000, 0);
    wait_done();
    check("t5_result2", 32'(result), 32'h4400);
    step();
    check("t5_done_count", 32'(n_done), 32'd2);

    // 6: reset during DRAIN
    clear_counts();
    start_job(8'd1);
    send_pair(16'h4000, 16'h4200, 0);
    check("t6_in_drain", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_mac_en", 32'(mac_en), 32'd0);
    check("t6_rst_result", 32'(result), 32'h0000);
    check("t6_rst_done", 32'(done), 32'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) step();
    check("t6_no_done", 32'(n_done), 32'd0);
    check("t6_idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
